// File: rtl/conv_enc_pkg.sv
// Shared definitions for the streaming convolutional encoder.
//   state_e      : serialiser FSM states
//   G_K3, G_K7   : stock generator sets, G0 in the upper K-bit slice, slice MSB taps the newest bit
//   conv_parity  : one code bit from an encoder window and one generator slice
package conv_enc_pkg;

    // Largest supported constraint length; windows/generators are zero-extended to this width.
    localparam int unsigned MAX_K = 9;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StTail
    } state_e;

    localparam logic [5:0]  G_K3 = {3'o7, 3'o5};
    localparam logic [13:0] G_K7 = {7'o171, 7'o133};

    function automatic logic conv_parity(input logic [MAX_K-1:0] window,
                                         input logic [MAX_K-1:0] g);
        return ^(window & g);
    endfunction

endpackage

// File: rtl/conv_encoder_stream_if.sv
// Valid/ready stream bundle used on both sides of the encoder.
//   data  : payload (W bits)
//   valid : payload/last valid
//   last  : final beat of a frame
//   ready : sink accepts the beat
// master drives data/valid/last, slave drives ready.
interface conv_encoder_stream_if #(
    parameter int unsigned W = 8
);
    logic [W-1:0] data;
    logic         valid;
    logic         last;
    logic         ready;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/conv_enc_core.sv
// Convolutional encoder datapath: (K-1)-bit shift register plus the combinational
// N_OUT-bit symbol for the current input bit.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous zeroing of the shift register
//   step       : commit the current bit into the shift register
//   b          : input bit for this step
//   sym        : {c0, ..., c(N_OUT-1)} for window {b, sr}, c0 in MSB
module conv_enc_core
    import conv_enc_pkg::*;
#(
    parameter int unsigned           K     = 7,
    parameter int unsigned           N_OUT = 2,
    parameter logic [N_OUT*K-1:0]    G_VEC = G_K7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             step,
    input  logic             b,
    output logic [N_OUT-1:0] sym
);

    logic [K-2:0] sr_q;
    logic [K-1:0] window;

    // sr_q[K-2] is the most recent past bit, so the window reads newest-first.
    assign window = {b, sr_q};

    always_comb begin
        sym = '0;
        for (int i = 0; i < N_OUT; i++) begin
            sym[N_OUT-1-i] = conv_parity(MAX_K'(window), MAX_K'(G_VEC[(N_OUT-1-i)*K +: K]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (clear) begin
            sr_q <= '0;
        end else if (step) begin
            sr_q <= window[K-1:1];
        end
    end

endmodule

// File: rtl/conv_encoder_stream.sv
// Rate-1/N_OUT convolutional encoder with byte input and symbol output streams.
// Bytes are serialised MSB-first; with TERMINATE=1 each frame is followed by K-1
// zero tail bits so the trellis ends in state 0.
//   clk, rst_n : clock, asynchronous active-low reset
//   soft_clr   : synchronous clear of FSM, shift register and output slot
//   in_bus     : byte stream (data=in_byte, last=in_last, ready=in_ready)
//   out_bus    : symbol stream (data=out_sym, W must equal N_OUT)
//   busy       : FSM not idle or a symbol is pending
module conv_encoder_stream
    import conv_enc_pkg::*;
#(
    parameter int unsigned        K         = 7,
    parameter int unsigned        N_OUT     = 2,
    parameter logic [N_OUT*K-1:0] G_VEC     = G_K7,
    parameter bit                 TERMINATE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  soft_clr,
    conv_encoder_stream_if.slave  in_bus,
    conv_encoder_stream_if.master out_bus,
    output logic                  busy
);

    localparam int unsigned CW = $clog2(K);
    typedef logic [CW-1:0] cnt_t;

    state_e           state_q;
    logic [7:0]       byte_q;
    logic             last_q;
    logic [2:0]       bit_idx_q;
    cnt_t             tail_cnt_q;
    logic [N_OUT-1:0] sym_q;
    logic             out_valid_q;
    logic             out_last_q;

    logic             adv;
    logic             cur_bit;
    logic             step;
    logic             in_ready;
    logic             accept;
    logic             sym_last;
    logic [N_OUT-1:0] core_sym;

    always_comb begin
        adv      = !out_valid_q || out_bus.ready;
        cur_bit  = 1'b0;
        step     = 1'b0;
        in_ready = 1'b0;
        sym_last = 1'b0;
        unique case (state_q)
            StIdle: in_ready = 1'b1;
            StShift: begin
                cur_bit = byte_q[bit_idx_q];
                step    = adv;
                if (bit_idx_q == 3'd0) begin
                    // Chaining: the next byte is taken on the same edge as the
                    // current byte's last bit, so out_ready reaches in_ready combinationally.
                    in_ready = adv && !last_q;
                    sym_last = last_q && !TERMINATE;
                end
            end
            StTail: begin
                step     = adv;
                sym_last = (tail_cnt_q == '0);
            end
            default: ;
        endcase
        // A clear wins over any coincident handshake or encode step.
        if (soft_clr) begin
            in_ready = 1'b0;
            step     = 1'b0;
        end
        accept = in_bus.valid && in_ready;
    end

    conv_enc_core #(
        .K     (K),
        .N_OUT (N_OUT),
        .G_VEC (G_VEC)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (soft_clr),
        .step  (step),
        .b     (cur_bit),
        .sym   (core_sym)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            byte_q      <= '0;
            last_q      <= 1'b0;
            bit_idx_q   <= '0;
            tail_cnt_q  <= '0;
            sym_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (soft_clr) begin
            state_q     <= StIdle;
            byte_q      <= '0;
            last_q      <= 1'b0;
            bit_idx_q   <= '0;
            tail_cnt_q  <= '0;
            sym_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            // The output slot only moves when it is empty or being drained.
            if (adv) begin
                out_valid_q <= step;
                out_last_q  <= step && sym_last;
                if (step) begin
                    sym_q <= core_sym;
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        byte_q    <= in_bus.data;
                        last_q    <= in_bus.last;
                        bit_idx_q <= 3'd7;
                        state_q   <= StShift;
                    end
                end
                StShift: begin
                    if (adv) begin
                        if (bit_idx_q != 3'd0) begin
                            bit_idx_q <= bit_idx_q - 3'd1;
                        end else if (last_q) begin
                            if (TERMINATE) begin
                                state_q    <= StTail;
                                tail_cnt_q <= cnt_t'(K - 2);
                            end else begin
                                state_q <= StIdle;
                            end
                        end else if (accept) begin
                            byte_q    <= in_bus.data;
                            last_q    <= in_bus.last;
                            bit_idx_q <= 3'd7;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StTail: begin
                    if (adv) begin
                        if (tail_cnt_q == '0) begin
                            state_q <= StIdle;
                        end else begin
                            tail_cnt_q <= tail_cnt_q - 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_bus.ready  = in_ready;
    assign out_bus.data  = sym_q;
    assign out_bus.valid = out_valid_q;
    assign out_bus.last  = out_last_q;
    assign busy          = (state_q != StIdle) || out_valid_q;

endmodule

// File: tb/tb_conv_encoder_stream.sv
// Directed bench for conv_encoder_stream.
// DUT 0: K=3 G={7,5} terminated; DUT 1: K=7 defaults; DUT 2: K=3 G={7,5} unterminated.
module tb_conv_encoder_stream;

    localparam logic [1:0] EXP_A5 [0:9] = '{2'b11, 2'b10, 2'b00, 2'b10, 2'b11,
                                            2'b11, 2'b10, 2'b00, 2'b10, 2'b11};
    // 0x3C chained after 0xA5 (encoder state 10 on entry), then two tail bits.
    localparam logic [1:0] EXP_3C [0:9] = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b10,
                                            2'b10, 2'b01, 2'b11, 2'b00, 2'b00};
    localparam logic [1:0] EXP_FF [0:13] = '{2'b11, 2'b01, 2'b10, 2'b01, 2'b01, 2'b00, 2'b11,
                                             2'b11, 2'b00, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    // 0x00 encoded from state (1,0) left behind by an unterminated 0xA5.
    localparam logic [1:0] EXP_00 [0:7] = '{2'b10, 2'b11, 2'b00, 2'b00,
                                            2'b00, 2'b00, 2'b00, 2'b00};

    logic       clk;
    logic       rst_n;
    logic       soft_clr;
    logic [7:0] t_byte;
    logic [2:0] t_valid;
    logic [2:0] t_last;
    logic [2:0] t_ready;
    logic [1:0] o_sym [3];
    logic [2:0] o_valid;
    logic [2:0] o_last;
    logic [2:0] i_ready;
    logic [2:0] o_busy;

    int tests_run;
    int tests_failed;

    logic [1:0] got_sym  [64];
    logic       got_last [64];
    int         got_cyc  [64];
    int         got_n;
    int         acc_cyc  [2];
    int         hold_bad;

    conv_encoder_stream_if #(.W(8)) ib0 ();
    conv_encoder_stream_if #(.W(8)) ib1 ();
    conv_encoder_stream_if #(.W(8)) ib2 ();
    conv_encoder_stream_if #(.W(2)) ob0 ();
    conv_encoder_stream_if #(.W(2)) ob1 ();
    conv_encoder_stream_if #(.W(2)) ob2 ();

    assign ib0.data = t_byte;      assign ib1.data = t_byte;      assign ib2.data = t_byte;
    assign ib0.valid = t_valid[0]; assign ib1.valid = t_valid[1]; assign ib2.valid = t_valid[2];
    assign ib0.last = t_last[0];   assign ib1.last = t_last[1];   assign ib2.last = t_last[2];
    assign ob0.ready = t_ready[0]; assign ob1.ready = t_ready[1]; assign ob2.ready = t_ready[2];
    assign i_ready = {ib2.ready, ib1.ready, ib0.ready};
    assign o_valid = {ob2.valid, ob1.valid, ob0.valid};
    assign o_last  = {ob2.last, ob1.last, ob0.last};
    assign o_sym[0] = ob0.data;
    assign o_sym[1] = ob1.data;
    assign o_sym[2] = ob2.data;

    conv_encoder_stream #(.K(3), .N_OUT(2), .G_VEC(6'o75), .TERMINATE(1'b1)) u_d3 (
        .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr),
        .in_bus(ib0), .out_bus(ob0), .busy(o_busy[0])
    );

    conv_encoder_stream u_d7 (
        .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr),
        .in_bus(ib1), .out_bus(ob1), .busy(o_busy[1])
    );

    conv_encoder_stream #(.K(3), .N_OUT(2), .G_VEC(6'o75), .TERMINATE(1'b0)) u_d3n (
        .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr),
        .in_bus(ib2), .out_bus(ob2), .busy(o_busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Feeds up to two bytes into DUT d and records every consumed symbol with its cycle.
    // Inputs change on the falling edge; comb outputs are read 1 ns later.
    // While out_ready is held low the presented symbol must stay valid and unchanged.
    task automatic collect(input int d, input int nb,
                           input logic [7:0] b0, input logic l0,
                           input logic [7:0] b1, input logic l1,
                           input int stall_at, input int stall_len);
        int         bi;
        int         stall_left;
        logic [1:0] hold_ref;
        logic       hold_set;
        for (int i = 0; i < 64; i++) begin
            got_sym[i]  = 'x;
            got_last[i] = 'x;
            got_cyc[i]  = -1;
        end
        got_n      = 0;
        hold_bad   = 0;
        bi         = 0;
        acc_cyc[0] = -1;
        acc_cyc[1] = -1;
        stall_left = stall_len;
        hold_set   = 1'b0;
        hold_ref   = '0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bi < nb) begin
                t_byte     = (bi == 0) ? b0 : b1;
                t_last[d]  = (bi == 0) ? l0 : l1;
                t_valid[d] = 1'b1;
            end else begin
                t_valid[d] = 1'b0;
                t_last[d]  = 1'b0;
            end
            t_ready[d] = !(got_n == stall_at && stall_left > 0);
            #1;
            if (t_valid[d] && i_ready[d]) begin
                acc_cyc[bi] = c;
                bi++;
            end
            if (!t_ready[d]) begin
                stall_left--;
                if (!hold_set) begin
                    hold_ref = o_sym[d];
                    hold_set = 1'b1;
                end
                if (!o_valid[d] || o_sym[d] !== hold_ref) hold_bad++;
            end
            if (o_valid[d] && t_ready[d] && got_n < 64) begin
                got_sym[got_n]  = o_sym[d];
                got_last[got_n] = o_last[d];
                got_cyc[got_n]  = c;
                got_n++;
            end
        end
        t_valid[d] = 1'b0;
        t_last[d]  = 1'b0;
        t_ready[d] = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            tests_run++;
            if (o_valid[d] !== 1'b0 || o_last[d] !== 1'b0 || o_sym[d] !== 2'b00 ||
                o_busy[d] !== 1'b0 || i_ready[d] !== 1'b1) begin
                tests_failed++;
                $display("FAIL reset dut%0d: valid=%b last=%b sym=%b busy=%b in_ready=%b, want 0 0 00 0 1",
                         d, o_valid[d], o_last[d], o_sym[d], o_busy[d], i_ready[d]);
            end
        end
    endtask

    task automatic test_basic();
        int gaps;
        collect(0, 1, 8'hA5, 1'b1, 8'h00, 1'b0, -1, 0);
        tests_run++;
        if (got_n !== 10) begin
            tests_failed++;
            $display("FAIL basic count: got %0d symbols, want 10", got_n);
        end
        gaps = 0;
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (got_sym[i] !== EXP_A5[i] || got_last[i] !== (i == 9)) begin
                tests_failed++;
                $display("FAIL basic sym[%0d]: got %b last=%b, want %b last=%b",
                         i, got_sym[i], got_last[i], EXP_A5[i], (i == 9));
            end
            if (got_cyc[i] != got_cyc[0] + i) gaps++;
        end
        tests_run++;
        if (gaps !== 0) begin
            tests_failed++;
            $display("FAIL basic spacing: %0d symbols off consecutive cycles, want 0", gaps);
        end
        // Accept on edge P0, first symbol registered on P1.
        tests_run++;
        if (got_cyc[0] !== acc_cyc[0] + 2) begin
            tests_failed++;
            $display("FAIL basic latency: first symbol cycle %0d, want %0d", got_cyc[0], acc_cyc[0] + 2);
        end
        tests_run++;
        if (o_busy[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic idle busy: got %b, want 0", o_busy[0]);
        end
    endtask

    task automatic test_backpressure();
        collect(0, 1, 8'hA5, 1'b1, 8'h00, 1'b0, 3, 5);
        tests_run++;
        if (got_n !== 10 || hold_bad !== 0) begin
            tests_failed++;
            $display("FAIL stall count/hold: got %0d symbols, %0d hold errors, want 10 and 0", got_n, hold_bad);
        end
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (got_sym[i] !== EXP_A5[i] || got_last[i] !== (i == 9)) begin
                tests_failed++;
                $display("FAIL stall sym[%0d]: got %b last=%b, want %b last=%b",
                         i, got_sym[i], got_last[i], EXP_A5[i], (i == 9));
            end
        end
    endtask

    task automatic test_k7();
        collect(1, 1, 8'hFF, 1'b1, 8'h00, 1'b0, -1, 0);
        tests_run++;
        if (got_n !== 14) begin
            tests_failed++;
            $display("FAIL k7 count: got %0d symbols, want 14", got_n);
        end
        for (int i = 0; i < 14; i++) begin
            tests_run++;
            if (got_sym[i] !== EXP_FF[i] || got_last[i] !== (i == 13)) begin
                tests_failed++;
                $display("FAIL k7 sym[%0d]: got %b last=%b, want %b last=%b",
                         i, got_sym[i], got_last[i], EXP_FF[i], (i == 13));
            end
        end
        tests_run++;
        if (u_d7.u_core.sr_q !== 6'd0) begin
            tests_failed++;
            $display("FAIL k7 final sr: got %b, want 000000", u_d7.u_core.sr_q);
        end
    endtask

    task automatic test_back_to_back();
        int         gaps;
        logic [1:0] exp_sym;
        collect(0, 2, 8'hA5, 1'b0, 8'h3C, 1'b1, -1, 0);
        tests_run++;
        if (got_n !== 18) begin
            tests_failed++;
            $display("FAIL chain count: got %0d symbols, want 18", got_n);
        end
        gaps = 0;
        for (int i = 0; i < 18; i++) begin
            exp_sym = (i < 8) ? EXP_A5[i] : EXP_3C[i-8];
            tests_run++;
            if (got_sym[i] !== exp_sym || got_last[i] !== (i == 17)) begin
                tests_failed++;
                $display("FAIL chain sym[%0d]: got %b last=%b, want %b last=%b",
                         i, got_sym[i], got_last[i], exp_sym, (i == 17));
            end
            if (got_cyc[i] != got_cyc[0] + i) gaps++;
        end
        tests_run++;
        if (gaps !== 0) begin
            tests_failed++;
            $display("FAIL chain spacing: %0d symbols off consecutive cycles, want 0", gaps);
        end
        // Second byte is taken on the edge that registers the first byte's bit 0.
        tests_run++;
        if (acc_cyc[1] !== acc_cyc[0] + 8) begin
            tests_failed++;
            $display("FAIL chain accept: second byte at cycle %0d, want %0d", acc_cyc[1], acc_cyc[0] + 8);
        end
    endtask

    task automatic test_clear(input logic use_rst);
        int n;
        @(negedge clk);
        t_byte     = 8'hA5;
        t_last[0]  = 1'b1;
        t_valid[0] = 1'b1;
        t_ready[0] = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(negedge clk);
            t_valid[0] = 1'b0;
            t_last[0]  = 1'b0;
            #1;
            if (o_valid[0]) n++;
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (o_valid[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear%0d pre: symbol 4 valid=%b, want 1", use_rst, o_valid[0]);
        end
        if (use_rst) rst_n = 1'b0;
        else         soft_clr = 1'b1;
        t_valid[0] = 1'b1;
        t_byte     = 8'hFF;
        @(negedge clk);
        t_valid[0] = 1'b0;
        soft_clr   = 1'b0;
        rst_n      = 1'b1;
        #1;
        tests_run++;
        if (o_valid[0] !== 1'b0 || i_ready[0] !== 1'b1 || o_busy[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear%0d post: valid=%b in_ready=%b busy=%b, want 0 1 0",
                     use_rst, o_valid[0], i_ready[0], o_busy[0]);
        end
        collect(0, 1, 8'hA5, 1'b1, 8'h00, 1'b0, -1, 0);
        tests_run++;
        if (got_n !== 10) begin
            tests_failed++;
            $display("FAIL clear%0d count: got %0d symbols, want 10", use_rst, got_n);
        end
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (got_sym[i] !== EXP_A5[i] || got_last[i] !== (i == 9)) begin
                tests_failed++;
                $display("FAIL clear%0d sym[%0d]: got %b last=%b, want %b last=%b",
                         use_rst, i, got_sym[i], got_last[i], EXP_A5[i], (i == 9));
            end
        end
    endtask

    task automatic test_no_terminate();
        collect(2, 1, 8'hA5, 1'b1, 8'h00, 1'b0, -1, 0);
        tests_run++;
        if (got_n !== 8) begin
            tests_failed++;
            $display("FAIL noterm a5 count: got %0d symbols, want 8", got_n);
        end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (got_sym[i] !== EXP_A5[i] || got_last[i] !== (i == 7)) begin
                tests_failed++;
                $display("FAIL noterm a5 sym[%0d]: got %b last=%b, want %b last=%b",
                         i, got_sym[i], got_last[i], EXP_A5[i], (i == 7));
            end
        end
        collect(2, 1, 8'h00, 1'b1, 8'h00, 1'b0, -1, 0);
        tests_run++;
        if (got_n !== 8) begin
            tests_failed++;
            $display("FAIL noterm 00 count: got %0d symbols, want 8", got_n);
        end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (got_sym[i] !== EXP_00[i] || got_last[i] !== (i == 7)) begin
                tests_failed++;
                $display("FAIL noterm 00 sym[%0d]: got %b last=%b, want %b last=%b",
                         i, got_sym[i], got_last[i], EXP_00[i], (i == 7));
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        soft_clr     = 1'b0;
        t_byte       = '0;
        t_valid      = '0;
        t_last       = '0;
        t_ready      = 3'b111;
        test_reset();
        test_basic();
        test_backpressure();
        test_k7();
        test_back_to_back();
        test_clear(1'b0);
        test_clear(1'b1);
        test_no_terminate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
